mips_instr_encoder: RTL and testbench
=====================================

// Module: mips_instr_encoder
// PURPOSE
//  Builds MIPS instruction words, the inverse of the opcode decoder in Control_unit.
//  Takes an instruction class plus operand fields through a valid/ready handshake.
//  Packs a 32-bit word whose opcode decodes back to that class.
//  Buffers the words in a small FIFO that feeds the instruction memory loader and test stimulus paths.
// PARAMETERS
//  DEPTH   4  FIFO entries; must be a power of 2, at least 2
//  ADDR_W  2  log2(DEPTH)
// PORTS
//  Clk        in   1       single clock; all state updates on posedge Clk
//  Reset      in   1       synchronous, active-high reset
//  In_valid   in   1       request present
//  In_ready   out  1       encoder can accept; equals !full && !Reset
//  In_class   in   3       0=R 1=ADDI 2=LW 3=SW 4=BEQ 5=J 6,7=illegal
//  In_rs      in   5       source register
//  In_rt      in   5       target register
//  In_rd      in   5       destination register (R only)
//  In_shamt   in   5       shift amount (R only)
//  In_funct   in   6       function code (R only)
//  In_imm     in   16      immediate/offset (ADDI, LW, SW, BEQ)
//  In_target  in   26      jump target (J only)
//  Out_valid  out  1       FIFO not empty
//  Out_ready  in   1       consumer takes the head word
//  Out_instr  out  32      head word; 0 when empty
//  Count      out  ADDR_W+1  occupancy, 0..DEPTH
//  Err_illegal out 1       sticky; set on any accepted illegal class
// BEHAVIOUR
//  Handshakes:
//  - accept = In_valid && In_ready
//  - pop    = Out_valid && Out_ready
//  - both complete at the posedge.
//  Encoding (combinational from In_*, written on accept):
//  - R    {6'b000000, rs, rt, rd, shamt, funct}
//  - ADDI {6'b001000, rs, rt, imm}
//  - LW   {6'b100011, rs, rt, imm}
//  - SW   {6'b101011, rs, rt, imm}
//  - BEQ  {6'b000100, rs, rt, imm}
//  - J    {6'b000010, target}
//  - Fields that a class does not use are ignored, never ORed into the word.
//  Illegal class (6, 7):
//  - The handshake still completes. Nothing is written and Count is unchanged.
//  - Err_illegal=1 from the next cycle until Reset.
//  Latency: a word accepted at edge N appears on Out_instr with Out_valid=1 after edge N
//  when the FIFO was empty. Otherwise it is presented in FIFO order.
//  FIFO:
//  - Circular buffer with wr_ptr/rd_ptr of ADDR_W bits that wrap from DEPTH-1 to 0.
//  - full = (Count==DEPTH), empty = (Count==0).
//  - Push and pop on the same edge: both happen and Count is unchanged. This is
//    legal only when the FIFO is non-empty and not full.
//  - Full: In_ready=0 and there is no write-through, even if Out_ready=1 in that cycle.
//  - Empty: Out_valid=0 and Out_instr=0. An accept has no same-cycle bypass to Out.
//  - Pop on an empty FIFO is a no-op. Push on a full FIFO cannot occur.
//  - Out_instr and Out_valid hold steady while Out_valid && !Out_ready.
//  Reset, checked at the edge, overrides everything, including mid-stream:
//  - Clears pointers and sets Count=0.
//  - Sets Out_valid=0, Out_instr=0, Err_illegal=0.
//  - In_ready=0 while Reset is high, and 1 the first cycle after it drops.
//  - Words held before Reset are discarded. Storage contents need no reset.
// TESTING
//  1. R: rs=1 rt=2 rd=3 shamt=0 funct=6'h20 -> Out_instr=32'h00221820 one cycle later.
//  2. ADDI rs=4 rt=5 imm=16'hFFFF -> 32'h2085FFFF. J target=26'h0000100 -> 32'h08000100.
//  3. Hold Out_ready=0 and push DEPTH LW words -> Count=4, In_ready=0. Then pop all four
//     in order and Count returns to 0.
//  4. With Count=2, push and pop every cycle for 10 cycles -> Count stays 2. Words
//     come out in order across pointer wrap.
//  5. Accept class 7 -> Count unchanged, Err_illegal=1 next cycle and it stays set.
//     Reset clears it.
//  6. Assert Reset with Count=3 -> next cycle Count=0, Out_valid=0, Out_instr=0.
//     In_ready=1 after Reset drops.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// MIPS instruction word encoder: packs a class plus operand fields into a 32-bit word
// and queues the words in a small circular FIFO for the downstream consumer.
module mips_instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [2:0]        In_class,
  input  logic [4:0]        In_rs,
  input  logic [4:0]        In_rt,
  input  logic [4:0]        In_rd,
  input  logic [4:0]        In_shamt,
  input  logic [5:0]        In_funct,
  input  logic [15:0]       In_imm,
  input  logic [25:0]       In_target,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [31:0]       Out_instr,
  output logic [ADDR_W:0]   Count,
  output logic              Err_illegal
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_legal;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Only the fields a class actually owns reach the word; everything else is dropped.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (In_class)
      3'd0:    w_word = {6'b000000, In_rs, In_rt, In_rd, In_shamt, In_funct};
      3'd1:    w_word = {6'b001000, In_rs, In_rt, In_imm};
      3'd2:    w_word = {6'b100011, In_rs, In_rt, In_imm};
      3'd3:    w_word = {6'b101011, In_rs, In_rt, In_imm};
      3'd4:    w_word = {6'b000100, In_rs, In_rt, In_imm};
      3'd5:    w_word = {6'b000010, In_target};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign In_ready    = !w_full && !Reset;
  assign Out_valid   = !w_empty;
  assign Out_instr   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign Count       = r_count;
  assign Err_illegal = r_err;

  // Illegal classes complete the handshake but never occupy a slot.
  assign w_accept = In_valid && In_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = Out_valid && Out_ready;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: a queue-based reference model predicts every
// word, and a negedge monitor compares the DUT outputs against it.
module tb_mips_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              In_valid;
  logic              In_ready;
  logic [2:0]        In_class;
  logic [4:0]        In_rs;
  logic [4:0]        In_rt;
  logic [4:0]        In_rd;
  logic [4:0]        In_shamt;
  logic [5:0]        In_funct;
  logic [15:0]       In_imm;
  logic [25:0]       In_target;
  logic              Out_valid;
  logic              Out_ready;
  logic [31:0]       Out_instr;
  logic [ADDR_W:0]   Count;
  logic              Err_illegal;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .In_valid    (In_valid),
    .In_ready    (In_ready),
    .In_class    (In_class),
    .In_rs       (In_rs),
    .In_rt       (In_rt),
    .In_rd       (In_rd),
    .In_shamt    (In_shamt),
    .In_funct    (In_funct),
    .In_imm      (In_imm),
    .In_target   (In_target),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Out_instr   (Out_instr),
    .Count       (Count),
    .Err_illegal (Err_illegal)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          fails  = 0;
  bit          monEn  = 1'b0;
  logic [31:0] expQ[$];
  bit          expErr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference encoding built from opcode/field positions with plain arithmetic.
  function automatic logic [31:0] refEncode(input int unsigned cls, input int unsigned rs,
      input int unsigned rt, input int unsigned rd, input int unsigned shamt,
      input int unsigned funct, input int unsigned imm, input int unsigned target);
    int unsigned opTable[6] = '{0, 8, 35, 43, 4, 2};
    int unsigned word;
    if (cls == 0)
      word = rs * (2**21) + rt * (2**16) + rd * (2**11) + shamt * (2**6) + funct;
    else if (cls == 5)
      word = opTable[5] * (2**26) + target;
    else
      word = opTable[cls] * (2**26) + rs * (2**21) + rt * (2**16) + imm;
    return word;
  endfunction

  // Model update at the active edge, using the inputs that were stable before it.
  always @(posedge Clk) begin
    bit popNow;
    bit accNow;
    if (Reset) begin
      expQ.delete();
      expErr = 1'b0;
    end else begin
      popNow = Out_ready && (expQ.size() > 0);
      accNow = In_valid && (expQ.size() < DEPTH);
      if (popNow) void'(expQ.pop_front());
      if (accNow) begin
        if (In_class < 3'd6)
          expQ.push_back(refEncode(In_class, In_rs, In_rt, In_rd, In_shamt, In_funct, In_imm, In_target));
        else
          expErr = 1'b1;
      end
    end
  end

  // Monitor compares everything the DUT presents against the model, mid-cycle.
  always @(negedge Clk) begin
    if (monEn) begin
      checkOutput("count", 32'(Count), 32'(expQ.size()));
      checkOutput("out_valid", 32'(Out_valid), 32'(expQ.size() > 0));
      checkOutput("out_instr", Out_instr, (expQ.size() > 0) ? expQ[0] : 32'h0);
      checkOutput("in_ready", 32'(In_ready), 32'(!Reset && (expQ.size() < DEPTH)));
      checkOutput("err_illegal", 32'(Err_illegal), 32'(expErr));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setFields(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
      input logic [15:0] imm, input logic [25:0] target);
    In_class  = cls;
    In_rs     = rs;
    In_rt     = rt;
    In_rd     = rd;
    In_shamt  = shamt;
    In_funct  = funct;
    In_imm    = imm;
    In_target = target;
  endtask

  task automatic applyStimulus(input logic [2:0] cls, input logic valid, input logic ready);
    setFields(cls, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
              16'($urandom), 26'($urandom));
    In_valid  = valid;
    Out_ready = ready;
    tick();
  endtask

  task automatic pulseReset();
    Reset    = 1'b1;
    In_valid = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic directedWord(input string name, input logic [31:0] expected);
    In_valid  = 1'b1;
    Out_ready = 1'b1;
    tick();
    In_valid = 1'b0;
    @(negedge Clk);
    checkOutput(name, Out_instr, expected);
    tick();
  endtask

  initial begin
    Reset = 1'b1;
    In_valid = 1'b0;
    Out_ready = 1'b0;
    setFields(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    tick();
    tick();
    monEn = 1'b1;
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("reset count", 32'(Count), 32'd0);
    checkOutput("reset in_ready", 32'(In_ready), 32'd1);
    tick();

    // Known encodings, with unused fields deliberately non-zero.
    setFields(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3FFFFFF);
    directedWord("R word", 32'h00221820);
    setFields(3'd1, 5'd4, 5'd5, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
    directedWord("ADDI word", 32'h2085FFFF);
    setFields(3'd5, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000100);
    directedWord("J word", 32'h08000100);

    // Fill to full without popping, then drain in order.
    for (int i = 0; i < DEPTH; i++) applyStimulus(3'd2, 1'b1, 1'b0);
    In_valid = 1'b0;
    @(negedge Clk);
    checkOutput("full count", 32'(Count), 32'(DEPTH));
    checkOutput("full in_ready", 32'(In_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(3'd2, 1'b0, 1'b1);
    @(negedge Clk);
    checkOutput("drained count", 32'(Count), 32'd0);
    tick();

    // Steady push+pop at Count=2 across pointer wrap.
    applyStimulus(3'd3, 1'b1, 1'b0);
    applyStimulus(3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'($urandom_range(0, 5)), 1'b1, 1'b1);
      @(negedge Clk);
      checkOutput("steady count", 32'(Count), 32'd2);
    end
    for (int i = 0; i < 3; i++) applyStimulus(3'd0, 1'b0, 1'b1);

    // Illegal class sets a sticky flag and writes nothing.
    applyStimulus(3'd7, 1'b1, 1'b0);
    In_valid = 1'b0;
    @(negedge Clk);
    checkOutput("illegal flag", 32'(Err_illegal), 32'd1);
    checkOutput("illegal count", 32'(Count), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(3'd1, 1'b0, 1'b0);
    @(negedge Clk);
    checkOutput("illegal sticky", 32'(Err_illegal), 32'd1);
    tick();
    pulseReset();
    @(negedge Clk);
    checkOutput("illegal cleared", 32'(Err_illegal), 32'd0);
    tick();

    // Reset mid-stream discards held words.
    for (int i = 0; i < 3; i++) applyStimulus(3'd1, 1'b1, 1'b0);
    pulseReset();
    @(negedge Clk);
    checkOutput("post-reset count", 32'(Count), 32'd0);
    checkOutput("post-reset valid", 32'(Out_valid), 32'd0);
    checkOutput("post-reset instr", Out_instr, 32'd0);
    checkOutput("post-reset ready", 32'(In_ready), 32'd1);
    tick();

    // Random traffic, including illegal classes, full back-pressure and stray resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 2) != 0));
      end
    end
    In_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(3'd0, 1'b0, 1'b1);
    @(negedge Clk);
    checkOutput("final drain", 32'(Count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
